// File: rtl/slice_demux_ctrl_pkg.sv
// Shared decoder definitions for the slice demux input sequencer.
// FSM state encoding, bitstream word geometry and a config sanity helper.
package slice_demux_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PPS    = 2'd1;
    localparam logic [1:0] ST_SOF    = 2'd2;
    localparam logic [1:0] ST_STREAM = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        PPS    = ST_PPS,
        SOF_ST = ST_SOF,
        STREAM = ST_STREAM
    } state_e;

    localparam int BYTES_PER_WORD = 32;
    localparam int PPS_BYTES      = 128;

    // A zero in any geometry field would make the frame end undefined.
    function automatic logic cfg_is_zero(input logic [9:0]  slices_per_line,
                                         input logic [15:0] chunk_size,
                                         input logic [15:0] frame_height);
        return (slices_per_line == '0) || (chunk_size == '0) || (frame_height == '0);
    endfunction

endpackage

// File: rtl/slice_chunk_tracker.sv
// Chunk / slice / line boundary tracker for a 32-byte-per-word bitstream.
// Shared with the encoder-side mux; last_word_o flags the word that closes the frame.
module slice_chunk_tracker
    import slice_demux_ctrl_pkg::*;
#(
    parameter int MAX_FRAME_HEIGHT = 8192
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        advance_i,
    input  logic [9:0]  slices_per_line_i,
    input  logic [15:0] chunk_size_i,
    input  logic [15:0] frame_height_i,
    output logic        last_word_o
);
    localparam int LW = $clog2(MAX_FRAME_HEIGHT + 1);

    logic [15:0]   byte_acc_q, byte_acc_d;
    logic [9:0]    slice_idx_q, slice_idx_d;
    logic [LW-1:0] line_cnt_q, line_cnt_d;
    logic [16:0]   sum;
    logic [9:0]    slice_inc;
    logic [LW-1:0] line_inc;
    logic          boundary;
    logic          line_wrap;

    // Boundary arithmetic; small chunks accumulate leftover bytes so only one boundary counts per word.
    always_comb begin
        sum         = {1'b0, byte_acc_q} + 17'(BYTES_PER_WORD);
        boundary    = (sum >= {1'b0, chunk_size_i});
        slice_inc   = slice_idx_q + 10'd1;
        line_inc    = line_cnt_q + LW'(1);
        line_wrap   = boundary && (slice_inc == slices_per_line_i);
        last_word_o = advance_i && line_wrap && (32'(line_inc) == 32'(frame_height_i));
        byte_acc_d  = byte_acc_q;
        slice_idx_d = slice_idx_q;
        line_cnt_d  = line_cnt_q;
        if (clear_i) begin
            byte_acc_d  = '0;
            slice_idx_d = '0;
            line_cnt_d  = '0;
        end else if (advance_i) begin
            if (boundary) begin
                byte_acc_d = 16'(sum - {1'b0, chunk_size_i});
                if (line_wrap) begin
                    slice_idx_d = '0;
                    line_cnt_d  = line_inc;
                end else begin
                    slice_idx_d = slice_inc;
                end
            end else begin
                byte_acc_d = sum[15:0];
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_acc_q  <= '0;
            slice_idx_q <= '0;
            line_cnt_q  <= '0;
        end else begin
            byte_acc_q  <= byte_acc_d;
            slice_idx_q <= slice_idx_d;
            line_cnt_q  <= line_cnt_d;
        end
    end

endmodule

// File: rtl/slice_demux_ctrl.sv
// Input sequencer in front of the decoder slice demux: splits the PPS header from
// payload, pulses start/end of frame and backpressures on any almost-full slice FIFO.
// Optional statistics counters: define SLICE_DEMUX_CTRL_STATS_EN.
//
// state  | meaning
// IDLE   | discard words until one arrives with in_first (PPS word 0)
// PPS    | forward remaining PPS header words
// SOF_ST | one cycle: pulse SOF, sample/check config, clear tracker
// STREAM | forward payload until the last line of the frame closes
module slice_demux_ctrl
    import slice_demux_ctrl_pkg::*;
#(
    parameter int MAX_NBR_SLICES   = 2,
    parameter int PPS_WORDS        = PPS_BYTES / BYTES_PER_WORD,
    parameter int MAX_FRAME_HEIGHT = 8192
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_i,
    input  logic [9:0]                slices_per_line_i,
    input  logic [15:0]               chunk_size_i,
    input  logic [15:0]               frame_height_i,
    input  logic [MAX_NBR_SLICES-1:0] fifo_afull_i,
    input  logic [255:0]              in_data_i,
    input  logic                      in_valid_i,
    input  logic                      in_first_i,
    output logic                      in_ready_o,
    output logic [255:0]              out_data_o,
    output logic                      out_valid_o,
    output logic                      out_sof_o,
    output logic                      out_is_pps_o,
    output logic                      frame_done_o,
    output logic                      cfg_err_o
`ifdef SLICE_DEMUX_CTRL_STATS_EN
    ,
    output logic [31:0]               stat_frames_o,
    output logic [31:0]               stat_stall_cycles_o
`endif
);
    localparam int PCW = $clog2(PPS_WORDS + 1);

    state_e        state_q, state_d;
    logic [PCW-1:0] pps_cnt_q, pps_cnt_d;
    logic          active_q;
    logic [9:0]    spl_q;
    logic [15:0]   cs_q, fh_q;
    logic          sample_cfg;
    logic          stall, accept, advance, clear, last_word;
    logic [255:0]  out_data_d;
    logic          out_valid_d, out_sof_d, out_is_pps_d, frame_done_d, cfg_err_d;

    assign stall  = |fifo_afull_i;
    assign accept = in_valid_i && in_ready_o;

    // Ready/next-state/output decode; flush overrides every transition.
    always_comb begin
        in_ready_o   = 1'b0;
        state_d      = state_q;
        pps_cnt_d    = pps_cnt_q;
        out_data_d   = out_data_o;
        out_valid_d  = 1'b0;
        out_sof_d    = 1'b0;
        out_is_pps_d = 1'b0;
        frame_done_d = 1'b0;
        cfg_err_d    = 1'b0;
        sample_cfg   = 1'b0;
        clear        = 1'b0;
        advance      = 1'b0;
        case (state_q)
            IDLE:          in_ready_o = active_q;
            PPS, STREAM:   in_ready_o = ~stall;
            default:       in_ready_o = 1'b0;
        endcase
        if (flush_i) begin
            state_d   = IDLE;
            pps_cnt_d = '0;
            clear     = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && in_first_i) begin
                        out_valid_d  = 1'b1;
                        out_is_pps_d = 1'b1;
                        out_data_d   = in_data_i;
                        pps_cnt_d    = PCW'(1);
                        state_d      = (PPS_WORDS == 1) ? SOF_ST : PPS;
                    end
                end
                PPS: begin
                    if (accept) begin
                        out_valid_d  = 1'b1;
                        out_is_pps_d = 1'b1;
                        out_data_d   = in_data_i;
                        pps_cnt_d    = pps_cnt_q + PCW'(1);
                        if (pps_cnt_d == PCW'(PPS_WORDS)) state_d = SOF_ST;
                    end
                end
                SOF_ST: begin
                    out_sof_d  = 1'b1;
                    sample_cfg = 1'b1;
                    clear      = 1'b1;
                    pps_cnt_d  = '0;
                    if (cfg_is_zero(slices_per_line_i, chunk_size_i, frame_height_i)) begin
                        cfg_err_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        state_d   = STREAM;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        advance     = 1'b1;
                        out_valid_d = 1'b1;
                        out_data_d  = in_data_i;
                        if (last_word) begin
                            frame_done_d = 1'b1;
                            state_d      = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, handshake enable and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pps_cnt_q    <= '0;
            active_q     <= 1'b0;
            out_data_o   <= '0;
            out_valid_o  <= 1'b0;
            out_sof_o    <= 1'b0;
            out_is_pps_o <= 1'b0;
            frame_done_o <= 1'b0;
            cfg_err_o    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pps_cnt_q    <= pps_cnt_d;
            active_q     <= 1'b1;
            out_data_o   <= out_data_d;
            out_valid_o  <= out_valid_d;
            out_sof_o    <= out_sof_d;
            out_is_pps_o <= out_is_pps_d;
            frame_done_o <= frame_done_d;
            cfg_err_o    <= cfg_err_d;
        end
    end

    // Frame geometry captured once per frame so mid-frame input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spl_q <= '0;
            cs_q  <= '0;
            fh_q  <= '0;
        end else if (sample_cfg) begin
            spl_q <= slices_per_line_i;
            cs_q  <= chunk_size_i;
            fh_q  <= frame_height_i;
        end
    end

    slice_chunk_tracker #(
        .MAX_FRAME_HEIGHT (MAX_FRAME_HEIGHT)
    ) u_tracker (
        .clk               (clk),
        .rst_n             (rst_n),
        .clear_i           (clear),
        .advance_i         (advance),
        .slices_per_line_i (spl_q),
        .chunk_size_i      (cs_q),
        .frame_height_i    (fh_q),
        .last_word_o       (last_word)
    );

`ifdef SLICE_DEMUX_CTRL_STATS_EN
    logic [31:0] stat_frames_q, stat_stall_cycles_q;

    // Frame counter wraps; stall-cycle counter saturates; neither is cleared by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_frames_q       <= '0;
            stat_stall_cycles_q <= '0;
        end else begin
            if (frame_done_o) stat_frames_q <= stat_frames_q + 32'd1;
            if (((state_q == PPS) || (state_q == STREAM)) && in_valid_i && stall
                && (stat_stall_cycles_q != '1))
                stat_stall_cycles_q <= stat_stall_cycles_q + 32'd1;
        end
    end

    assign stat_frames_o       = stat_frames_q;
    assign stat_stall_cycles_o = stat_stall_cycles_q;
`endif

endmodule

// File: tb/tb_slice_demux_ctrl.sv
// Scoreboard bench for slice_demux_ctrl: a frame-level reference model predicts
// handshake and output events; a separate monitor compares DUT outputs to the queue.
module tb_slice_demux_ctrl;
    localparam int PPS_WORDS = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic [9:0]   slices_per_line = '0;
    logic [15:0]  chunk_size = '0;
    logic [15:0]  frame_height = '0;
    logic [1:0]   fifo_afull = '0;
    logic [255:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_first = 1'b0;
    logic         in_ready;
    logic [255:0] out_data;
    logic         out_valid, out_sof, out_is_pps, frame_done, cfg_err;

    slice_demux_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush_i           (flush),
        .slices_per_line_i (slices_per_line),
        .chunk_size_i      (chunk_size),
        .frame_height_i    (frame_height),
        .fifo_afull_i      (fifo_afull),
        .in_data_i         (in_data),
        .in_valid_i        (in_valid),
        .in_first_i        (in_first),
        .in_ready_o        (in_ready),
        .out_data_o        (out_data),
        .out_valid_o       (out_valid),
        .out_sof_o         (out_sof),
        .out_is_pps_o      (out_is_pps),
        .frame_done_o      (frame_done),
        .cfg_err_o         (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         valid;
        logic [255:0] data;
        logic         pps;
        logic         sof;
        logic         done;
        logic         err;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: 0 idle, 1 header, 2 sof, 3 payload
    int   m_state = 0;
    int   m_pps = 0;
    int   m_words = 0;
    int   m_target = 0;
    bit   m_active = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Payload words in a frame: each boundary needs ceil(chunk/32) words of bytes when
    // chunks are at least a word; smaller chunks are capped at one boundary per word.
    function automatic int frame_words(input int spl, input int cs, input int fh);
        int b = spl * fh;
        if (cs >= 32) return (b * cs + 31) / 32;
        return b;
    endfunction

    function automatic bit model_ready();
        if (!m_active) return 0;
        case (m_state)
            0:       return 1;
            1, 3:    return (fifo_afull == 2'b00);
            default: return 0;
        endcase
    endfunction

    function automatic logic [255:0] rand_word();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    // One clock: inputs already driven at the falling edge.
    task automatic tick();
        bit   rdy, acc, push;
        exp_t e;
        #1;
        rdy = model_ready();
        check("in_ready", {255'b0, in_ready}, {255'b0, rdy});
        acc  = in_valid && rdy;
        e    = '0;
        push = 0;
        @(posedge clk);
        if (flush) begin
            m_state = 0;
            m_pps   = 0;
        end else begin
            case (m_state)
                0: if (acc && in_first) begin
                    e.valid = 1; e.data = in_data; e.pps = 1; push = 1;
                    m_pps = 1;
                    m_state = (m_pps == PPS_WORDS) ? 2 : 1;
                end
                1: if (acc) begin
                    e.valid = 1; e.data = in_data; e.pps = 1; push = 1;
                    m_pps++;
                    if (m_pps == PPS_WORDS) m_state = 2;
                end
                2: begin
                    e.sof = 1; push = 1;
                    if (slices_per_line == 0 || chunk_size == 0 || frame_height == 0) begin
                        e.err = 1;
                        m_state = 0;
                    end else begin
                        m_target = frame_words(int'(slices_per_line), int'(chunk_size), int'(frame_height));
                        m_words  = 0;
                        m_state  = 3;
                    end
                end
                default: if (acc) begin
                    m_words++;
                    e.valid = 1; e.data = in_data; push = 1;
                    if (m_words == m_target) begin
                        e.done  = 1;
                        m_state = 0;
                    end
                end
            endcase
        end
        if (push) exp_q.push_back(e);
        m_active = 1;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [255:0] d, input logic first, input bit rnd);
        bit acc;
        int guard = 0;
        do begin
            if (rnd && $urandom_range(0, 3) == 0) begin
                in_valid = 0; in_first = 0; fifo_afull = 0;
                tick();
            end
            in_valid = 1; in_first = first; in_data = d;
            fifo_afull = (rnd && $urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            acc = model_ready();
            tick();
            guard++;
        end while (!acc && guard < 50);
        if (!acc) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: word not accepted after %0d cycles", guard);
        end
        in_valid = 0; in_first = 0; fifo_afull = 0;
    endtask

    task automatic set_cfg(input int spl, input int cs, input int fh);
        slices_per_line = 10'(spl);
        chunk_size      = 16'(cs);
        frame_height    = 16'(fh);
    endtask

    task automatic send_pps(input bit rnd);
        for (int i = 0; i < PPS_WORDS; i++) send_word(rand_word(), (i == 0), rnd);
    endtask

    // Full frame; optional flush after N payload words, optional stall window after word 8.
    task automatic run_frame(input int spl, input int cs, input int fh, input bit rnd,
                             input int flush_after, input bit stall5);
        int words = 0;
        set_cfg(spl, cs, fh);
        send_pps(rnd);
        while (m_state != 0 && words < 3000) begin
            if (flush_after >= 0 && words == flush_after) begin
                flush = 1; in_valid = 1; in_data = rand_word();
                tick();
                flush = 0; in_valid = 0;
                break;
            end
            if (stall5 && words == 8) begin
                in_valid = 1; in_data = rand_word(); fifo_afull = 2'b01;
                for (int i = 0; i < 5; i++) tick();
                fifo_afull = 2'b00; in_valid = 0;
            end
            send_word(rand_word(), 0, rnd);
            words++;
        end
        repeat (2) tick();
    endtask

    task automatic check_reset_outputs();
        #1;
        check("rst_in_ready",   {255'b0, in_ready},   256'd0);
        check("rst_out_valid",  {255'b0, out_valid},  256'd0);
        check("rst_out_sof",    {255'b0, out_sof},    256'd0);
        check("rst_out_is_pps", {255'b0, out_is_pps}, 256'd0);
        check("rst_frame_done", {255'b0, frame_done}, 256'd0);
        check("rst_cfg_err",    {255'b0, cfg_err},    256'd0);
        check("rst_out_data",   out_data,             256'd0);
    endtask

    task automatic do_reset();
        rst_n = 0;
        check_reset_outputs();
        m_state = 0; m_pps = 0; m_words = 0; m_active = 0;
        exp_q.delete();
        in_valid = 0; in_first = 0; flush = 0; fifo_afull = 0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n = 1;
    endtask

    // Monitor: pop and compare on every cycle the DUT presents any output event.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && (out_valid || out_sof || frame_done || cfg_err)) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_output: valid=%0b sof=%0b done=%0b err=%0b expected none",
                             out_valid, out_sof, frame_done, cfg_err);
                end else begin
                    e = exp_q.pop_front();
                    check("out_valid",  {255'b0, out_valid},  {255'b0, e.valid});
                    check("out_is_pps", {255'b0, out_is_pps}, {255'b0, e.pps});
                    check("out_sof",    {255'b0, out_sof},    {255'b0, e.sof});
                    check("frame_done", {255'b0, frame_done}, {255'b0, e.done});
                    check("cfg_err",    {255'b0, cfg_err},    {255'b0, e.err});
                    if (e.valid) check("out_data", out_data, e.data);
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        do_reset();

        // garbage in idle, then nominal frame
        for (int i = 0; i < 3; i++) send_word(rand_word(), 0, 0);
        repeat (2) tick();
        run_frame(2, 100, 3, 0, -1, 0);

        // backpressure window mid-payload
        run_frame(2, 100, 3, 0, -1, 1);

        // chunk smaller than a word
        run_frame(1, 16, 4, 0, -1, 0);

        // chunk exactly one word
        run_frame(3, 32, 2, 0, -1, 0);

        // bad config: zero slices, then a stray word is discarded
        run_frame(0, 100, 3, 0, -1, 0);
        send_word(rand_word(), 0, 0);
        repeat (2) tick();
        run_frame(2, 100, 0, 0, -1, 0);

        // flush after payload word 7, then a full frame
        run_frame(2, 100, 3, 0, 7, 0);
        run_frame(2, 100, 3, 0, -1, 0);

        // flush racing in_first in idle
        flush = 1; in_valid = 1; in_first = 1; in_data = rand_word();
        tick();
        flush = 0; in_valid = 0; in_first = 0;
        repeat (2) tick();

        // reset mid-frame, then recover
        set_cfg(2, 100, 3);
        send_pps(0);
        for (int i = 0; i < 5; i++) send_word(rand_word(), 0, 0);
        do_reset();
        run_frame(1, 64, 2, 0, -1, 0);

        // randomized frames with stalls, gaps and occasional flush
        for (int f = 0; f < 25; f++) begin
            int fl;
            fl = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 6) : -1;
            run_frame($urandom_range(1, 3), $urandom_range(8, 160), $urandom_range(1, 4), 1, fl, 0);
        end

        repeat (4) tick();
        check("queue_empty", 256'(exp_q.size()), 256'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/slice_demux_ctrl.md
Name: slice_demux_ctrl

Overview:
Input sequencer placed directly in front of the slice demultiplexer in the decoder. It accepts the 256-bit compressed bitstream through a valid/ready handshake and separates the 128-byte PPS header from the slice payload. It issues the start-of-frame pulse, forwards payload words while tracking chunk, slice and line boundaries to find the end of the frame, and applies backpressure when any per-slice rate-buffer FIFO is almost full.

Parameters:
MAX_NBR_SLICES, 2, number of per-slice FIFOs downstream; width of fifo_afull.
PPS_WORDS, 4, number of 32-byte words in the PPS header (128 bytes).
MAX_FRAME_HEIGHT, 8192, maximum frame height in lines; sets the line counter width to $clog2(MAX_FRAME_HEIGHT+1).

Ports:
clk  input  1  core clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous abort; returns the block to IDLE.
slices_per_line  input  10  slices per line; sampled in SOF_ST.
chunk_size  input  16  bytes per chunk; sampled in SOF_ST.
frame_height  input  16  lines per frame; sampled in SOF_ST.
fifo_afull  input  MAX_NBR_SLICES  per-slice FIFO almost-full flags.
in_data  input  256  bitstream word.
in_valid  input  1  in_data valid.
in_first  input  1  qualifies the first word of a frame (PPS word 0).
in_ready  output  1  word accepted when in_valid & in_ready.
out_data  output  256  word to the demux.
out_valid  output  1  out_data valid.
out_sof  output  1  single-cycle start-of-frame pulse to the demux.
out_is_pps  output  1  high while out_data carries a PPS word.
frame_done  output  1  single-cycle pulse after the last payload word is forwarded.
cfg_err  output  1  single-cycle pulse when sampled configuration is zero.

Behaviour:
- Reset: state=IDLE. in_ready=0, out_valid=0, out_sof=0, out_is_pps=0, frame_done=0, cfg_err=0, out_data=0, all counters 0.
- Handshake and latency:
  - accept = in_valid & in_ready.
  - Accepted words appear on out_data/out_valid exactly 1 cycle later (registered).
  - out_valid is 0 in any cycle with no accept.
- FSM states: IDLE, PPS, SOF_ST, STREAM.
- IDLE:
  - in_ready=1.
  - Words without in_first are accepted and discarded.
  - A word with in_first is forwarded with out_is_pps=1, pps_cnt=1, next state PPS.
- PPS:
  - in_ready = ~stall, where stall = |fifo_afull.
  - Each accept is forwarded with out_is_pps=1 and increments pps_cnt.
  - The accept that brings pps_cnt to PPS_WORDS moves the FSM to SOF_ST.
- SOF_ST (exactly one cycle):
  - in_ready=0; out_sof=1 next cycle with out_valid=0.
  - Samples the config inputs and clears byte_acc, slice_idx and line_cnt.
  - If any sampled value is 0: cfg_err pulse, next state IDLE. Otherwise next state STREAM.
- STREAM:
  - in_ready = ~stall. Each accept is forwarded with out_is_pps=0.
  - Per accept, sum = byte_acc + 32 (17-bit arithmetic).
  - If sum >= chunk_size: byte_acc = sum - chunk_size and slice_idx increments.
  - When slice_idx reaches slices_per_line it resets to 0 and line_cnt increments.
  - If sum < chunk_size: byte_acc = sum.
  - chunk_size < 32 is legal; at most one boundary is counted per word.
  - Frame ends on the accept where line_cnt becomes frame_height. frame_done pulses together with that word's out_valid, and the next state is IDLE.
  - Trailing pad bytes in the final word are forwarded unchanged.
- in_first seen outside IDLE: the word is treated as a normal word. No resync; the upstream stage must flush.
- Stall:
  - fifo_afull is sampled combinationally into in_ready with no register.
  - A stall during PPS or STREAM holds all counters.
- flush:
  - Has priority over every transition.
  - Next cycle: state=IDLE; out_valid, out_sof, out_is_pps and frame_done are 0; counters cleared.
  - A word accepted in the flush cycle is dropped.
- Simultaneous flush & in_first in IDLE: flush wins and the word is dropped.
- Reset asserted mid-frame: immediate return to reset values; no partial frame_done.

Optional Feature:
- Macro: SLICE_DEMUX_CTRL_STATS_EN.
- When defined, adds two outputs:
  - stat_frames (32 bits): increments on each frame_done and wraps.
  - stat_stall_cycles (32 bits): increments each cycle in PPS or STREAM with in_valid & stall; saturates at all-ones.
- Both counters reset to 0 on rst_n only; flush does not clear them.
- When undefined, neither port nor logic exists and behaviour is otherwise identical.

Decomposition:
- Shared decoder package holds:
  - FSM state encoding (2-bit localparams IDLE/PPS/SOF_ST/STREAM);
  - BYTES_PER_WORD=32;
  - PPS_BYTES=128.
- One sub-module: slice_chunk_tracker. It holds byte_acc, slice_idx and line_cnt, with inputs clear and advance and output last_word. It is reusable by the encoder-side mux.

Test Plan:
- Nominal frame: slices_per_line=2, chunk_size=100, frame_height=3, PPS word 0 with in_first -> 4 PPS words with out_is_pps=1, out_sof pulse, 19 payload words (6 chunks = 600 B), frame_done with word 19, FSM in IDLE.
- Backpressure: fifo_afull=2'b01 held for 5 cycles mid-STREAM -> in_ready=0 for those 5 cycles, no out_valid, and the frame still ends at payload word 19.
- Small chunk: chunk_size=16, slices_per_line=1, frame_height=4 -> one boundary counted per word; frame_done on payload word 4.
- Bad config: slices_per_line=0 -> out_sof pulse, cfg_err pulse, FSM returns to IDLE, next in_valid is discarded.
- Flush mid-STREAM after payload word 7 -> out_valid=0 next cycle; a new in_first frame then decodes completely.
- Garbage in IDLE: 3 words without in_first -> accepted, out_valid stays 0; the following in_first frame proceeds normally.
